pixel_addr_gen: RTL and testbench

//  Pixel-to-framebuffer address stage between the gl_core_internal pixel FIFO and fbwriter2.
//  - Pops 96-bit pixel words from the FIFO and clips them against the screen.
//  - Converts surviving pixels into (address, colour) write commands on a valid/ready port.
//  - Backpressure from fbwriter2 (the PLB master) throttles FIFO reads through slot reservation.

---
 rtl/pixel_addr_gen_pkg.sv | 32 +++
 rtl/pixel_addr_gen_if.sv | 10 +
 rtl/pixel_addr_gen_sync_fifo.sv | 57 +++++
 rtl/pixel_addr_gen.sv | 124 ++++++++++++
 tb/tb_pixel_addr_gen.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_addr_gen_pkg.sv
// Shared definitions for the pixel-to-framebuffer address stage: pixel word layout,
// default screen geometry and the linear byte-offset helper.
package pixel_addr_gen_pkg;

    localparam int PIX_X_MSB    = 95;
    localparam int PIX_X_LSB    = 80;
    localparam int PIX_Y_MSB    = 79;
    localparam int PIX_Y_LSB    = 64;
    localparam int PIX_RSVD_MSB = 63;
    localparam int PIX_RSVD_LSB = 32;
    localparam int PIX_ARGB_MSB = 31;
    localparam int PIX_ARGB_LSB = 0;

    localparam int DEF_FB_WIDTH        = 640;
    localparam int DEF_FB_HEIGHT       = 480;
    localparam int DEF_BYTES_PER_PIXEL = 4;
    localparam int DEF_OUTQ_DEPTH      = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] argb;
    } fb_cmd_t;

    // Only meaningful for on-screen coordinates; x and y are treated as unsigned.
    function automatic logic [31:0] pixel_offset(input logic [15:0] x, input logic [15:0] y,
                                                 input int width, input int bpp);
        logic [31:0] idx;
        idx = 32'(y) * 32'(width) + 32'(x);
        return idx * 32'(bpp);
    endfunction

endpackage

// File: rtl/pixel_addr_gen_if.sv
// Framebuffer write-command port: one (address, colour) pair per valid/ready handshake.
interface pixel_addr_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;

    modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/pixel_addr_gen_sync_fifo.sv
// Small first-word-fall-through FIFO; the head entry is visible on pop_data whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count_reg != '0);
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push & ((count_reg != FULL_CNT) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

endmodule

// File: rtl/pixel_addr_gen.sv
// Pops pixel words, clips them to the screen and turns survivors into framebuffer write
// commands; FIFO reads are throttled by reserving an output-queue slot per pixel in flight.
module pixel_addr_gen
    import pixel_addr_gen_pkg::*;
#(
    parameter int FB_WIDTH        = DEF_FB_WIDTH,
    parameter int FB_HEIGHT       = DEF_FB_HEIGHT,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int OUTQ_DEPTH      = DEF_OUTQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [31:0]            fb_base,
    input  logic [95:0]            pixel_fifo_dout,
    input  logic                   pixel_fifo_empty,
    output logic                   pixel_fifo_rd_en,
    pixel_addr_gen_if.master       cmd,
    output logic                   idle,
    output logic [31:0]            pix_cnt,
    output logic [31:0]            clip_cnt
);
    localparam int QCW = $clog2(OUTQ_DEPTH) + 1;
    localparam int OW  = QCW + 1;

    logic [1:0]     rst_sync_reg;
    logic           rst_n_int;

    logic           s1_valid_reg;
    logic [15:0]    s1_x;
    logic [15:0]    s1_y;
    logic           s1_clip;

    logic           s2_valid_reg;
    logic           s2_clip_reg;
    logic [31:0]    s2_offset_reg;
    logic [31:0]    s2_argb_reg;

    logic           q_push;
    fb_cmd_t        q_push_data;
    fb_cmd_t        q_pop_data;
    logic           q_empty;
    logic [QCW-1:0] q_count;
    logic           handshake;
    logic [OW-1:0]  in_flight;
    logic           slot_free;

    logic [31:0]    pix_cnt_reg;
    logic [31:0]    clip_cnt_reg;
    logic           unused_rsvd;

    // Assert asynchronously, release two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n_int = rst_sync_reg[1];

    // Every pixel in S1/S2 owns a queue entry, so the queue can never overflow.
    assign in_flight        = OW'(s1_valid_reg) + OW'(s2_valid_reg) + OW'(q_count);
    assign slot_free        = (in_flight < OW'(OUTQ_DEPTH));
    assign pixel_fifo_rd_en = rst_n_int & enable & ~pixel_fifo_empty & slot_free;

    assign s1_x        = pixel_fifo_dout[PIX_X_MSB:PIX_X_LSB];
    assign s1_y        = pixel_fifo_dout[PIX_Y_MSB:PIX_Y_LSB];
    assign unused_rsvd = ^pixel_fifo_dout[PIX_RSVD_MSB:PIX_RSVD_LSB];

    // Bit 15 set means negative; otherwise an unsigned compare against the screen size.
    assign s1_clip = s1_x[15] | (s1_x >= 16'(FB_WIDTH)) |
                     s1_y[15] | (s1_y >= 16'(FB_HEIGHT));

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_clip_reg   <= 1'b0;
            s2_offset_reg <= '0;
            s2_argb_reg   <= '0;
        end else begin
            s1_valid_reg  <= pixel_fifo_rd_en;
            s2_valid_reg  <= s1_valid_reg;
            s2_clip_reg   <= s1_clip;
            s2_offset_reg <= pixel_offset(s1_x, s1_y, FB_WIDTH, BYTES_PER_PIXEL);
            s2_argb_reg   <= pixel_fifo_dout[PIX_ARGB_MSB:PIX_ARGB_LSB];
        end
    end

    assign q_push           = s2_valid_reg & ~s2_clip_reg;
    assign q_push_data.addr = fb_base + s2_offset_reg;
    assign q_push_data.argb = s2_argb_reg;
    assign handshake        = ~q_empty & cmd.cmd_ready;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (OUTQ_DEPTH)
    ) u_outq (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (handshake),
        .pop_data  (q_pop_data),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pix_cnt_reg  <= '0;
            clip_cnt_reg <= '0;
        end else begin
            if (handshake)                  pix_cnt_reg  <= pix_cnt_reg + 32'd1;
            if (s2_valid_reg & s2_clip_reg) clip_cnt_reg <= clip_cnt_reg + 32'd1;
        end
    end

    assign cmd.cmd_valid = ~q_empty;
    assign cmd.cmd_addr  = q_pop_data.addr;
    assign cmd.cmd_data  = q_pop_data.argb;
    assign pix_cnt       = pix_cnt_reg;
    assign clip_cnt      = clip_cnt_reg;
    assign idle          = ~s1_valid_reg & ~s2_valid_reg & q_empty & pixel_fifo_empty;

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Directed and random stimulus for pixel_addr_gen with a queue-based scoreboard and an
// independent command monitor.
module tb_pixel_addr_gen;
    import pixel_addr_gen_pkg::*;

    localparam int W = 640;
    localparam int H = 480;

    typedef struct packed {
        logic [95:0] word;
        logic [63:0] exp_cmd;
        logic        pass;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] fb_base;
    logic [95:0] pixel_fifo_dout;
    logic        pixel_fifo_empty;
    logic        pixel_fifo_rd_en;
    logic        idle;
    logic [31:0] pix_cnt;
    logic [31:0] clip_cnt;

    pixel_addr_gen_if cmd_bus();

    pixel_addr_gen dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .fb_base          (fb_base),
        .pixel_fifo_dout  (pixel_fifo_dout),
        .pixel_fifo_empty (pixel_fifo_empty),
        .pixel_fifo_rd_en (pixel_fifo_rd_en),
        .cmd              (cmd_bus),
        .idle             (idle),
        .pix_cnt          (pix_cnt),
        .clip_cnt         (clip_cnt)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    pix_t fifo_q[$];
    logic [63:0] exp_q[$];
    int   pops = 0, model_pass = 0, model_clip = 0, hs_cnt = 0;
    int   first_rd_cyc = -1, first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1;
    int   stop_after = -1;
    int   ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_pix(input int x, input int y, input logic [31:0] argb,
                            input logic [31:0] exp_addr, input logic pass);
        pix_t p;
        logic [15:0] xs, ys;
        xs = 16'(x);
        ys = 16'(y);
        p.word    = {xs, ys, 32'($urandom), argb};
        p.exp_cmd = {exp_addr, argb};
        p.pass    = pass;
        fifo_q.push_back(p);
        pixel_fifo_empty = 1'b0;
    endtask

    task automatic push_random(input logic [31:0] base);
        int x, y;
        logic pass;
        logic [31:0] addr;
        x    = int'($urandom_range(0, 760)) - 60;
        y    = int'($urandom_range(0, 600)) - 60;
        pass = (x >= 0) && (x < W) && (y >= 0) && (y < H);
        addr = base + 32'((y * W + x) * 4);
        push_pix(x, y, $urandom, addr, pass);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(idle && fifo_q.size() == 0) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_drain"}, 64'(idle && fifo_q.size() == 0), 64'd1);
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    // FIFO model: standard read mode, word appears on dout the cycle after rd_en.
    initial begin
        pix_t p;
        logic pop_now;
        forever begin
            @(negedge clk);
            pop_now = pixel_fifo_rd_en;
            if (pop_now && first_rd_cyc < 0) first_rd_cyc = cyc;
            @(posedge clk); #1;
            if (pop_now) begin
                if (fifo_q.size() == 0) begin
                    check("fifo_underflow", 64'd1, 64'd0);
                end else begin
                    p = fifo_q.pop_front();
                    pixel_fifo_dout = p.word;
                    pops++;
                    if (p.pass) begin
                        exp_q.push_back(p.exp_cmd);
                        model_pass++;
                    end else begin
                        model_clip++;
                        $display("pixel clipped x=%0d y=%0d", $signed(p.word[95:80]), $signed(p.word[79:64]));
                    end
                    if (pops == stop_after) enable = 1'b0;
                end
            end
            pixel_fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       cmd_bus.cmd_ready = 1'($urandom_range(0, 1));
                2:       cmd_bus.cmd_ready = ~cmd_bus.cmd_ready;
                default: ;
            endcase
        end
    end

    // Command monitor: pops the scoreboard on every handshake.
    initial begin
        logic [63:0] e;
        logic [63:0] held;
        logic        hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 64'(cmd_bus.cmd_valid), 64'd1);
                    check("hold_stable", {cmd_bus.cmd_addr, cmd_bus.cmd_data}, held);
                end
                if (cmd_bus.cmd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
                    hs_cnt++;
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                    $display("cmd %0d addr=0x%08h data=0x%08h", hs_cnt, cmd_bus.cmd_addr, cmd_bus.cmd_data);
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", {cmd_bus.cmd_addr, cmd_bus.cmd_data}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd", {cmd_bus.cmd_addr, cmd_bus.cmd_data}, e);
                    end
                end
                hold = cmd_bus.cmd_valid & ~cmd_bus.cmd_ready;
                held = {cmd_bus.cmd_addr, cmd_bus.cmd_data};
            end
        end
    end

    initial begin
        int pops_before, hs_before, remaining, base_total;
        reset_n          = 1'b0;
        enable           = 1'b0;
        fb_base          = 32'h0;
        pixel_fifo_dout  = '0;
        pixel_fifo_empty = 1'b1;
        cmd_bus.cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        check("rst_rd_en", 64'(pixel_fifo_rd_en), 64'd0);
        check("rst_pix_cnt", 64'(pix_cnt), 64'd0);
        check("rst_clip_cnt", 64'(clip_cnt), 64'd0);
        check("rst_addr", 64'(cmd_bus.cmd_addr), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single pixel: (2*640+3)*4 = 0x140C, latency 3.
        fb_base = 32'h1000_0000;
        cmd_bus.cmd_ready = 1'b1;
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        push_pix(3, 2, 32'hFF00_FF00, 32'h1000_140C, 1'b1);
        enable = 1'b1;
        wait_drain("t1", 50);
        check("t1_latency", 64'(first_valid_cyc - first_rd_cyc), 64'd3);
        check("t1_pix_cnt", 64'(pix_cnt), 64'd1);

        // Clipping boundaries; (479*640+639)*4 = 0x12BFFC.
        push_pix(-1, 5, 32'h1111_1111, 32'h0, 1'b0);
        push_pix(640, 5, 32'h2222_2222, 32'h0, 1'b0);
        push_pix(10, 480, 32'h3333_3333, 32'h0, 1'b0);
        push_pix(639, 479, 32'h4444_4444, 32'h1012_BFFC, 1'b1);
        push_pix(0, -1, 32'h5555_5555, 32'h0, 1'b0);
        push_pix(0, 0, 32'h6666_6666, 32'h1000_0000, 1'b1);
        wait_drain("t2", 80);
        check("t2_clip_cnt", 64'(clip_cnt), 64'd4);
        check("t2_pix_cnt", 64'(pix_cnt), 64'd3);

        // Backpressure: only OUTQ_DEPTH reads while blocked, then back-to-back drain.
        cmd_bus.cmd_ready = 1'b0;
        pops_before = pops;
        for (int i = 0; i < 10; i++)
            push_pix(i * 7, i * 3, 32'hA000_0000 + 32'(i), 32'h1000_0000 + 32'(i * 7708), 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("t3_rd_pulses", 64'(pops - pops_before), 64'd4);
        check("t3_rd_en_low", 64'(pixel_fifo_rd_en), 64'd0);
        hs_before = hs_cnt;
        first_hs_cyc = -1;
        cmd_bus.cmd_ready = 1'b1;
        wait_drain("t3", 100);
        check("t3_count", 64'(hs_cnt - hs_before), 64'd10);
        check("t3_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd9);

        // enable drops after the third read.
        enable = 1'b0;
        hs_before = hs_cnt;
        for (int i = 0; i < 8; i++)
            push_pix(100 + i, 7, 32'hB000_0000 + 32'(i), 32'h1000_0000 + 32'((7 * 640 + 100 + i) * 4), 1'b1);
        stop_after = pops + 3;
        enable = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("t4_cmds", 64'(hs_cnt - hs_before), 64'd3);
        check("t4_pix_cnt", 64'(pix_cnt), 64'(model_pass));
        check("t4_idle", 64'(idle), 64'd0);
        check("t4_rd_en_low", 64'(pixel_fifo_rd_en), 64'd0);
        stop_after = -1;
        enable = 1'b1;
        wait_drain("t4", 100);

        // Reset mid-burst with cmd_ready toggling.
        ready_mode = 2;
        for (int i = 0; i < 6; i++)
            push_pix(20 + i, 30, 32'hC000_0000 + 32'(i), 32'h1000_0000 + 32'((30 * 640 + 20 + i) * 4), 1'b1);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        model_pass = 0;
        model_clip = 0;
        #1;
        check("t5_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        check("t5_pix_cnt", 64'(pix_cnt), 64'd0);
        check("t5_clip_cnt", 64'(clip_cnt), 64'd0);
        check("t5_rd_en", 64'(pixel_fifo_rd_en), 64'd0);
        check("t5_addr", 64'(cmd_bus.cmd_addr), 64'd0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        ready_mode = 0;
        cmd_bus.cmd_ready = 1'b1;
        remaining = fifo_q.size();
        hs_before = hs_cnt;
        wait_drain("t5", 100);
        check("t5_resume", 64'(hs_cnt - hs_before), 64'(remaining));
        check("t5_pix_after", 64'(pix_cnt), 64'(remaining));

        // Random stream with random backpressure.
        base_total = model_pass + model_clip;
        fb_base = 32'h2000_0000;
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) push_random(32'h2000_0000);
        wait_drain("t6", 20000);
        check("t6_total", 64'(pix_cnt + clip_cnt - 32'(base_total)), 64'd1000);
        check("t6_pix_cnt", 64'(pix_cnt), 64'(model_pass));
        check("t6_clip_cnt", 64'(clip_cnt), 64'(model_clip));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
